instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: number of instruction buffer entries.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fetch_enable_i  input  1  permits new fetch requests.
REQ-007 instr_req_o  output  1  memory request.
REQ-008 instr_addr_o  output  WORD_WIDTH  request address, bits [1:0] always 2'b00.
REQ-009 instr_gnt_i  input  1  request accepted this cycle.
REQ-010 instr_rvalid_i  input  1  read data valid, one or more cycles after grant.
REQ-011 instr_rdata_i  input  WORD_WIDTH  fetched instruction word.
REQ-012 instr_valid_o  output  1  buffer head valid toward decode.
REQ-013 instr_rdata_o  output  WORD_WIDTH  buffer head instruction.
REQ-014 instr_pc_o  output  WORD_WIDTH  buffer head address.
REQ-015 instr_ready_i  input  1  decode accepts head; pop when valid and ready are both high.
REQ-016 branch_i  input  1  one-cycle redirect strobe.
REQ-017 branch_addr_i  input  WORD_WIDTH  redirect target; bits [1:0] ignored.
REQ-018 fetch_err_o  output  1  fetch address out of memory range.

Function
REQ-019 States: IDLE, FETCH and ERR. IDLE->FETCH when fetch_enable_i=1. FETCH->IDLE when fetch_enable_i=0 and no request is pending. FETCH->ERR when the next PC is >= INSTR_MEM_SIZE. ERR->FETCH on branch_i with an in-range target.
REQ-020 instr_req_o=1 only when all of the following hold:
- state is FETCH;
- branch_i=0;
- outstanding=0, or instr_rvalid_i=1;
- fifo_count + outstanding - pop < FIFO_DEPTH.
REQ-021 At most one granted request is outstanding; a new request may be granted in the same cycle the previous rvalid returns.
REQ-022 Once raised, instr_req_o and instr_addr_o hold stable until instr_gnt_i=1, unless branch_i or reset intervenes.
REQ-023 On grant:
- the granted address is latched as pending_pc;
- outstanding is set;
- PC increments by 4, with 32-bit wrap.
REQ-024 On instr_rvalid_i with outstanding=1 and no discard pending: push {pending_pc, instr_rdata_i} and clear outstanding.
REQ-025 instr_rvalid_i with outstanding=0 is ignored.
REQ-026 There is no bypass: data becomes visible on instr_valid_o the cycle after rvalid.
REQ-027 Buffer behaviour: FIFO order; simultaneous push and pop when full is legal; instr_rdata_o and instr_pc_o hold while instr_valid_o=1 and instr_ready_i=0.
REQ-028 branch_i has priority over all other events. On the branch edge:
- the FIFO is flushed;
- PC is set to {branch_addr_i[31:2],2'b00};
- instr_req_o=0 in the branch cycle;
- an ungranted request is abandoned;
- an rvalid arriving in the same cycle is dropped;
- an outstanding request not yet returned sets discard, and its response is dropped and clears discard.
REQ-029 New requests after a branch start the next cycle, and still require outstanding=0 or an arriving rvalid.
REQ-030 Out of range: no request is ever issued to an address >= INSTR_MEM_SIZE. In ERR, fetch_err_o=1 and the buffer still drains.
REQ-031 Dropping fetch_enable_i never cancels an outstanding request; its response is still pushed.

Reset
REQ-032 While rst_n=0:
- state=IDLE;
- PC=BOOT_ADDR;
- FIFO empty;
- outstanding=0 and discard=0;
- instr_req_o=0, instr_valid_o=0, fetch_err_o=0;
- instr_addr_o=BOOT_ADDR;
- instr_rdata_o=0 and instr_pc_o=0.
REQ-033 Reset asserted mid-transaction discards all in-flight state; a late rvalid after reset release with outstanding=0 is ignored.

Structure
REQ-034 The riscv_defines package holds WORD_WIDTH, INSTR_MEM_SIZE and the fetch_state_t enum (IDLE, FETCH, ERR).
REQ-035 Sub-module instr_fifo: a synchronous FIFO with FIFO_DEPTH entries, push, pop and flush, count output, flush dominant.

Verification
REQ-036 Reset release, enable=1, memory with gnt=req and rvalid one cycle later, ready=1 -> addresses 0x00, 0x04, 0x08 issued on consecutive cycles; instr_pc_o sequence 0x00, 0x04, 0x08, one per cycle.
REQ-037 ready=0 for 5 cycles -> exactly 2 entries buffered and req stays low; ready=1 -> pops 2 entries in order, and req resumes in the first pop cycle.
REQ-038 gnt held low for 3 cycles -> req=1 with addr stable at 0x0c for all 3 cycles; the single grant yields a single push.
REQ-039 branch_i to 0x1e while a request to 0x10 is outstanding -> FIFO empty next cycle, the 0x10 response is dropped, and the next request address is 0x1c.
REQ-040 INSTR_MEM_SIZE=0x20, sequential fetch -> last request 0x1c, fetch_err_o=1, no request to 0x20; branch_i to 0x00 -> fetch_err_o=0 and 0x00 is fetched.
REQ-041 rst_n pulsed low while outstanding=1 -> all outputs at their reset values, and a following rvalid pushes nothing.

Source files
------------

// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared fetch-stage types and constants
// Contents: WORD_WIDTH, INSTR_MEM_SIZE (first invalid instruction address),
// fetch_state_t FSM encoding, and fetch_entry_t, the buffered {pc, data} pair.
package riscv_defines;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] INSTR_MEM_SIZE = 32'h0000_0020;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERR   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous instruction buffer with dominant flush
// Ports: clk, rst_n (async active-low), flush (clears all entries, wins over
// push/pop), push/push_data (write), pop (drop head), head_data/valid (head
// entry), count (number of stored entries). Push while full is accepted only
// together with a pop.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid     = (count != '0);
    assign do_pop    = pop && valid;
    assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with single-outstanding memory port
// Ports: clk, rst_n (async active-low); fetch_enable_i; memory side
// instr_req_o/instr_addr_o/instr_gnt_i/instr_rvalid_i/instr_rdata_i; decode side
// instr_valid_o/instr_rdata_o/instr_pc_o/instr_ready_i; branch_i/branch_addr_i
// redirect; fetch_err_o when the PC has run past INSTR_MEM_SIZE.
module instr_fetch
    import riscv_defines::*;
#(
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic [WORD_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  fetch_err_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t          state, next_state;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pending_pc;
    logic                  outstanding;
    logic                  discard;
    logic                  req_pending;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_valid;
    fetch_entry_t          head;
    fetch_entry_t          push_entry;
    logic                  pop;
    logic                  push;
    logic                  grant;
    logic [CW:0]           occupancy;
    logic                  space;
    logic [WORD_WIDTH-1:0] branch_pc;
    logic                  unused_branch_bits;

    assign branch_pc          = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
    assign unused_branch_bits = ^branch_addr_i[1:0];

    assign pop   = fifo_valid && instr_ready_i;
    assign grant = instr_req_o && instr_gnt_i;
    // A late response for a request abandoned by a branch is swallowed here.
    assign push  = instr_rvalid_i && outstanding && !discard && !branch_i;

    // Slots already promised: stored entries plus the one in flight, minus
    // the head leaving this cycle.
    assign occupancy = {1'b0, fifo_count} + (CW + 1)'(outstanding) - (CW + 1)'(pop);
    assign space     = occupancy < (CW + 1)'(FIFO_DEPTH);

    // req_pending keeps an ungranted request alive even if fetch_enable_i
    // drops, so the request/address pair never retracts before its grant.
    always_comb begin
        instr_req_o = 1'b0;
        if (state == FETCH && !branch_i && (!outstanding || instr_rvalid_i) && space
            && (pc < INSTR_MEM_SIZE) && (fetch_enable_i || req_pending)) begin
            instr_req_o = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fetch_enable_i) next_state = FETCH;
            end
            FETCH: begin
                if (!branch_i) begin
                    if (pc >= INSTR_MEM_SIZE) begin
                        next_state = ERR;
                    end else if (!fetch_enable_i && !outstanding && !instr_req_o) begin
                        next_state = IDLE;
                    end
                end
            end
            ERR: begin
                if (branch_i && (branch_pc < INSTR_MEM_SIZE)) next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= {BOOT_ADDR[WORD_WIDTH-1:2], 2'b00};
            pending_pc  <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            state       <= next_state;
            req_pending <= instr_req_o && !instr_gnt_i;

            if (branch_i)   pc <= branch_pc;
            else if (grant) pc <= pc + 32'd4;

            if (grant) pending_pc <= pc;

            if (grant)               outstanding <= 1'b1;
            else if (instr_rvalid_i) outstanding <= 1'b0;

            if (branch_i && outstanding && !instr_rvalid_i) discard <= 1'b1;
            else if (instr_rvalid_i && outstanding)         discard <= 1'b0;
        end
    end

    assign push_entry = '{pc: pending_pc, data: instr_rdata_i};

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (branch_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign instr_addr_o  = pc;
    assign instr_valid_o = fifo_valid;
    assign instr_rdata_o = fifo_valid ? head.data : '0;
    assign instr_pc_o    = fifo_valid ? head.pc : '0;
    assign fetch_err_o   = (state == ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
    import riscv_defines::*;

    localparam logic [31:0] BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        fetch_err_o;

    always #5 clk = ~clk;

    instr_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetch_enable_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_rdata_o(instr_rdata_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .fetch_err_o(fetch_err_o)
    );

    int n_tests = 0;
    int n_fail = 0;

    // memory responder
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat = 1;          // 0 = random 1..3
    bit          gnt_random = 0;
    logic [31:0] hold_addr = '0;
    int          hold_cnt = 0;

    // reference model: what decode should see, in order
    logic [63:0] exp_q[$];
    bit          model_out, model_drop;
    logic [31:0] model_pc;

    // per-cycle observations and pre-cycle expectations
    logic        o_req, o_gnt, o_rvalid, o_valid, o_err;
    logic [31:0] o_addr, o_pc, o_data;
    bit          e_valid, e_out;
    logic [31:0] e_pc, e_data, e_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_out = 0;
        model_drop = 0;
        model_pc = BOOT;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fetch_enable_i = 0; branch_i = 0; instr_ready_i = 0;
        instr_gnt_i = 0; instr_rvalid_i = 0;
        mem_busy = 0; hold_cnt = 0; gnt_random = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive memory response, observe, grant, update model, advance.
    task automatic cycle();
        int l;
        instr_rvalid_i = mem_busy && (mem_cnt == 0);
        instr_rdata_i = instr_rvalid_i ? mem_word(mem_addr) : $urandom;
        instr_gnt_i = 1'b0;
        #1;
        o_req = instr_req_o; o_addr = instr_addr_o; o_valid = instr_valid_o;
        o_pc = instr_pc_o; o_data = instr_rdata_o; o_err = fetch_err_o;
        o_rvalid = instr_rvalid_i;
        if (o_req) begin
            if (hold_cnt > 0 && o_addr == hold_addr) hold_cnt--;
            else instr_gnt_i = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        o_gnt = instr_gnt_i;
        e_valid = exp_q.size() > 0;
        e_pc = e_valid ? exp_q[0][63:32] : '0;
        e_data = e_valid ? exp_q[0][31:0] : '0;
        e_addr = model_pc;
        e_out = model_out;
        if (branch_i) begin
            exp_q.delete();
            if (model_out && !o_rvalid) model_drop = 1;
            else if (model_out) begin model_out = 0; model_drop = 0; end
            model_pc = {branch_addr_i[31:2], 2'b00};
        end else begin
            if (o_valid && instr_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            if (o_rvalid && model_out) begin
                if (!model_drop) exp_q.push_back({mem_addr, mem_word(mem_addr)});
                model_out = 0;
                model_drop = 0;
            end
            if (o_gnt) begin model_out = 1; model_pc = model_pc + 32'd4; end
        end
        if (o_rvalid) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (o_gnt) begin
            l = (lat > 0) ? lat : int'($urandom_range(1, 3));
            mem_busy = 1; mem_addr = o_addr; mem_cnt = l - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_enable_i = 1; instr_rvalid_i = 1; instr_gnt_i = 1; instr_ready_i = 1;
        repeat (2) @(posedge clk);
        #3;
        n_tests++; if (instr_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", instr_req_o); end
        n_tests++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid_o); end
        n_tests++; if (fetch_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err_o); end
        n_tests++; if (instr_addr_o !== BOOT) begin n_fail++; $display("FAIL reset_addr: got %h want %h", instr_addr_o, BOOT); end
        n_tests++; if (instr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", instr_rdata_o); end
        n_tests++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc_o); end
        apply_reset();
    endtask

    task automatic test_sequential();
        int rc[$]; logic [31:0] ra[$]; int pcc[$]; logic [31:0] pcs[$];
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 1; lat = 1;
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (o_req && o_gnt) begin rc.push_back(c); ra.push_back(o_addr); end
            if (o_valid) begin pcc.push_back(c); pcs.push_back(o_pc); end
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ra.size() <= i || ra[i] !== 32'(4 * i) || (i > 0 && rc[i] != rc[i-1] + 1)) begin
                n_fail++; $display("FAIL seq_req[%0d]: got %h want %h on consecutive cycles", i, (ra.size() > i) ? ra[i] : 32'hx, 32'(4 * i));
            end
            n_tests++;
            if (pcs.size() <= i || pcs[i] !== 32'(4 * i) || (i > 0 && pcc[i] != pcc[i-1] + 1)) begin
                n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h on consecutive cycles", i, (pcs.size() > i) ? pcs[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        int grants = 0; int bad_hold = 0;
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 0; lat = 1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (o_gnt) grants++;
            if (o_valid && o_pc !== 32'h0) bad_hold++;
        end
        n_tests++; if (grants != 2) begin n_fail++; $display("FAIL bp_grants: got %0d want 2", grants); end
        n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low: got %b want 0", o_req); end
        n_tests++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_head_hold: got %0d changed cycles want 0", bad_hold); end
        instr_ready_i = 1;
        cycle();
        n_tests++; if (!(o_valid && o_pc === 32'h0)) begin n_fail++; $display("FAIL bp_pop0: got valid=%b pc=%h want 1/0", o_valid, o_pc); end
        n_tests++; if (!(o_req && o_addr === 32'h8)) begin n_fail++; $display("FAIL bp_req_resume: got req=%b addr=%h want 1/8", o_req, o_addr); end
        cycle();
        n_tests++; if (!(o_valid && o_pc === 32'h4 && o_data === mem_word(32'h4))) begin n_fail++; $display("FAIL bp_pop1: got pc=%h data=%h want 4/%h", o_pc, o_data, mem_word(32'h4)); end
        cycle();
        n_tests++; if (!(o_valid && o_pc === 32'h8)) begin n_fail++; $display("FAIL bp_pop2: got valid=%b pc=%h want 1/8", o_valid, o_pc); end
    endtask

    task automatic test_gnt_hold();
        int nheld = 0, ngr = 0, npop = 0, first_h = -1, last_h = -1, gcyc = -1;
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 1; lat = 1;
        hold_addr = 32'hc; hold_cnt = 3;
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (o_req && o_addr === 32'hc && !o_gnt) begin nheld++; if (first_h < 0) first_h = c; last_h = c; end
            if (o_req && o_addr === 32'hc && o_gnt) begin ngr++; gcyc = c; end
            if (o_valid && instr_ready_i && o_pc === 32'hc) npop++;
        end
        n_tests++; if (nheld != 3 || last_h - first_h != 2) begin n_fail++; $display("FAIL hold_stable: got %0d held cycles (span %0d) want 3 consecutive", nheld, last_h - first_h); end
        n_tests++; if (ngr != 1 || gcyc != last_h + 1) begin n_fail++; $display("FAIL hold_grant: got %0d grants at %0d want 1 at %0d", ngr, gcyc, last_h + 1); end
        n_tests++; if (npop != 1) begin n_fail++; $display("FAIL hold_push: got %0d entries for 0xc want 1", npop); end
    endtask

    task automatic test_branch_discard();
        bit found = 0; bit got_req = 0; bit got_pc = 0; int bad10 = 0;
        logic [31:0] first_req = 'x, first_pc = 'x;
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 1; lat = 3;
        for (int c = 0; c < 30 && !found; c++) begin
            cycle();
            if (o_req && o_gnt && o_addr === 32'h10) found = 1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL br_reach_0x10: got no grant want grant of 0x10 within 30 cycles"); end
        branch_i = 1; branch_addr_i = 32'h1e;
        cycle();
        branch_i = 0;
        n_tests++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL br_req_low: got %b want 0", o_req); end
        cycle();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: got valid=%b want 0", o_valid); end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cycle();
            if (o_req && !got_req) begin got_req = 1; first_req = o_addr; end
            if (o_valid && !got_pc) begin got_pc = 1; first_pc = o_pc; end
            if (o_valid && o_pc === 32'h10) bad10++;
        end
        n_tests++; if (first_req !== 32'h1c) begin n_fail++; $display("FAIL br_next_req: got %h want 1c", first_req); end
        n_tests++; if (first_pc !== 32'h1c || bad10 != 0) begin n_fail++; $display("FAIL br_drop: got first pc %h (%0d stale) want 1c", first_pc, bad10); end
    endtask

    task automatic test_mem_range();
        logic [31:0] last_gnt = 'x; int bad = 0;
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 1; lat = 1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (o_req && o_addr >= INSTR_MEM_SIZE) bad++;
            if (o_req && o_gnt) last_gnt = o_addr;
        end
        n_tests++; if (last_gnt !== 32'h1c) begin n_fail++; $display("FAIL rng_last: got %h want 1c", last_gnt); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rng_oob_req: got %0d want 0", bad); end
        n_tests++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL rng_err: got %b want 1", o_err); end
        branch_i = 1; branch_addr_i = 32'h0;
        cycle();
        branch_i = 0;
        cycle();
        n_tests++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rng_err_clear: got %b want 0", o_err); end
        n_tests++; if (!(o_req && o_addr === 32'h0)) begin n_fail++; $display("FAIL rng_refetch: got req=%b addr=%h want 1/0", o_req, o_addr); end
    endtask

    task automatic test_reset_mid();
        bit found = 0; int bad = 0;
        apply_reset();
        fetch_enable_i = 1; instr_ready_i = 1; lat = 3;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle();
            if (o_gnt) found = 1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rst_mid_grant: got none want a grant"); end
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0 || fetch_err_o !== 1'b0 ||
            instr_addr_o !== BOOT || instr_rdata_o !== 32'h0 || instr_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got req=%b valid=%b err=%b addr=%h rdata=%h pc=%h want reset values",
                     instr_req_o, instr_valid_o, fetch_err_o, instr_addr_o, instr_rdata_o, instr_pc_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        fetch_enable_i = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (o_valid !== 1'b0 || o_req !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_mid_late_rvalid: got %0d cycles with valid/req want 0", bad); end
    endtask

    task automatic test_random();
        bit prev_hold = 0; logic [31:0] prev_addr = '0; bit br;
        apply_reset();
        lat = 0; gnt_random = 1;
        for (int c = 0; c < 3000; c++) begin
            fetch_enable_i = ($urandom_range(0, 7) != 0);
            instr_ready_i = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 11) == 0);
            branch_i = br;
            branch_addr_i = 32'($urandom_range(0, 47));
            cycle();
            branch_i = 0;
            n_tests++;
            if (o_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, o_valid, e_valid); end
            else if (e_valid) begin
                n_tests++;
                if (o_pc !== e_pc || o_data !== e_data) begin n_fail++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, o_pc, o_data, e_pc, e_data); end
            end
            if (o_req) begin
                n_tests++;
                if (o_addr !== e_addr || o_addr >= INSTR_MEM_SIZE) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h (< %h)", c, o_addr, e_addr, INSTR_MEM_SIZE); end
                n_tests++;
                if (br) begin n_fail++; $display("FAIL rnd_req_on_branch c%0d: got 1 want 0", c); end
                n_tests++;
                if (e_out && !o_rvalid) begin n_fail++; $display("FAIL rnd_two_outstanding c%0d: got req=1 want 0", c); end
            end
            if (prev_hold && !br) begin
                n_tests++;
                if (!o_req || o_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_req_stable c%0d: got req=%b addr=%h want 1/%h", c, o_req, o_addr, prev_addr); end
            end
            prev_hold = o_req && !o_gnt;
            prev_addr = o_addr;
        end
        gnt_random = 0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_gnt_hold();
        test_branch_discard();
        test_mem_range();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
